// File: rtl/quickq_pkg.sv
// Shared QuickQ types and defaults: dequeue FSM state encoding and default array depth.
package quickq_pkg;

    localparam int QQ_DEPTH_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMPTY,
        S_RD_HEAD,
        S_HEAD,
        S_SH_RD,
        S_SH_WR,
        S_COMMIT
    } deq_state_t;

endpackage

// File: rtl/quickq_deq_engine.sv
// QuickQ dequeue engine: pops the minimum (address 0) of the sorted BRAM array,
// shifts the remaining entries down by one address and publishes the new count.
module quickq_deq_engine
    import quickq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = QQ_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              deq_req,
    input  logic [ADDR_W-1:0] count_in,
    output logic              busy,
    output logic              deq_valid,
    output logic [DATA_W-1:0] deq_data,
    output logic              deq_empty,
    output logic [ADDR_W-1:0] count_out,
    output logic              count_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

    deq_state_t        state, state_n;
    logic [ADDR_W-1:0] cnt_q, idx_q;
    logic [DATA_W-1:0] head_q;
    logic [ADDR_W-1:0] count_clamped;
    logic [ADDR_W-1:0] idx_next;

    assign count_clamped = (count_in > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : count_in;
    assign idx_next      = idx_q + ADDR_W'(1);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt_q  <= '0;
            idx_q  <= '0;
            head_q <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE:  if (deq_req) cnt_q <= count_clamped;
                S_HEAD: begin
                    head_q <= bram_rdata;
                    idx_q  <= ADDR_W'(1);
                end
                S_SH_WR: idx_q <= idx_next;
                default: ;
            endcase
        end
    end

    // NOTE: every output and next-state signal gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_n    = state;
        busy       = (state != S_IDLE);
        deq_valid  = 1'b0;
        deq_data   = '0;
        deq_empty  = 1'b0;
        count_out  = '0;
        count_we   = 1'b0;
        bram_addr  = '0;
        bram_we    = 1'b0;
        bram_wdata = '0;

        case (state)
            S_IDLE: begin
                if (deq_req) state_n = (count_clamped == '0) ? S_EMPTY : S_RD_HEAD;
            end
            S_EMPTY: begin
                deq_empty = 1'b1;
                state_n   = S_IDLE;
            end
            S_RD_HEAD: begin
                bram_addr = '0;
                state_n   = S_HEAD;
            end
            S_HEAD: begin
                state_n = (cnt_q == ADDR_W'(1)) ? S_COMMIT : S_SH_RD;
            end
            S_SH_RD: begin
                bram_addr = idx_q;
                state_n   = S_SH_WR;
            end
            S_SH_WR: begin
                // Read data for idx_q arrives now; move it one slot down.
                bram_addr  = idx_q - ADDR_W'(1);
                bram_we    = 1'b1;
                bram_wdata = bram_rdata;
                state_n    = (idx_next == cnt_q) ? S_COMMIT : S_SH_RD;
            end
            S_COMMIT: begin
                // The stale top slot is left as is; the count bounds validity.
                deq_valid = 1'b1;
                deq_data  = head_q;
                count_we  = 1'b1;
                count_out = cnt_q - ADDR_W'(1);
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_quickq_deq_engine.sv
// Directed bench for quickq_deq_engine with a behavioural BRAM and a scoreboard
// of expected dequeue results.
module tb_quickq_deq_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        deq_req;
    logic [31:0] count_in;
    logic        busy, deq_valid, deq_empty, count_we, bram_we;
    logic [31:0] deq_data, count_out, bram_addr, bram_wdata, bram_rdata;

    logic [31:0] mem [16];
    logic        ld_we;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;

    typedef struct {
        logic        empty;
        logic [31:0] data;
        logic [31:0] cnt;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_wr     = 0;
    int   n_val    = 0;

    quickq_deq_engine #(.DATA_W(32), .ADDR_W(32), .DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .deq_req    (deq_req),
        .count_in   (count_in),
        .busy       (busy),
        .deq_valid  (deq_valid),
        .deq_data   (deq_data),
        .deq_empty  (deq_empty),
        .count_out  (count_out),
        .count_we   (count_we),
        .bram_addr  (bram_addr),
        .bram_we    (bram_we),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read BRAM; the bench preloads it through the ld_* port.
    always @(posedge clk) begin
        bram_rdata <= mem[bram_addr[3:0]];
        if (bram_we)
            mem[bram_addr[3:0]] <= bram_wdata;
        else if (ld_we)
            mem[ld_addr] <= ld_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to the next falling edge and score any DUT result seen there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (bram_we) n_wr++;
        if (deq_valid) n_val++;
        if (deq_valid || deq_empty) begin
            check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ev_empty", 32'(deq_empty), 32'(e.empty));
                check("ev_valid", 32'(deq_valid), 32'(!e.empty));
                check("ev_count_we", 32'(count_we), 32'(!e.empty));
                if (!e.empty) begin
                    check("deq_data", deq_data, e.data);
                    check("count_out", count_out, e.cnt);
                end
                if (e.lat >= 0) check("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    endtask

    task automatic set_word(input int a, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = 4'(a);
        ld_data = d;
        tick();
        ld_we   = 1'b0;
    endtask

    task automatic push_exp(input logic empty, input logic [31:0] d, input logic [31:0] c, input int lat);
        exp_t e;
        e.empty = empty;
        e.data  = d;
        e.cnt   = c;
        e.lat   = lat;
        e.t0    = cyc;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) tick();
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        deq_req  = 1'b0;
        count_in = '0;
        ld_we    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        repeat (3) tick();

        // Reset state: idle, every output low
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_deq_valid", 32'(deq_valid), 32'd0);
        check("rst_deq_empty", 32'(deq_empty), 32'd0);
        check("rst_count_we", 32'(count_we), 32'd0);
        check("rst_bram_we", 32'(bram_we), 32'd0);
        check("rst_bram_addr", bram_addr, 32'd0);
        check("rst_deq_data", deq_data, 32'd0);
        rst = 1'b0;
        tick();

        // 1) four entries: shift down, head 3 at T+9
        set_word(0, 3); set_word(1, 7); set_word(2, 9); set_word(3, 12);
        n_wr = 0;
        count_in = 4;
        push_exp(1'b0, 32'd3, 32'd3, 9);
        deq_req = 1'b1;
        tick();
        deq_req = 1'b0;
        drain(20);
        check("t1_writes", 32'(n_wr), 32'd3);
        check("t1_mem0", mem[0], 32'd7);
        check("t1_mem1", mem[1], 32'd9);
        check("t1_mem2", mem[2], 32'd12);
        check("t1_mem3_stale", mem[3], 32'd12);
        tick();

        // 2) single entry: T+3, no writes
        set_word(0, 42);
        n_wr = 0;
        count_in = 1;
        push_exp(1'b0, 32'd42, 32'd0, 3);
        deq_req = 1'b1;
        tick();
        deq_req = 1'b0;
        drain(10);
        check("t2_writes", 32'(n_wr), 32'd0);
        tick();

        // 3) empty array: deq_empty at T+1, idle at T+2
        n_wr = 0;
        count_in = 0;
        push_exp(1'b1, 32'd0, 32'd0, 1);
        deq_req = 1'b1;
        tick();
        deq_req = 1'b0;
        check("t3_busy_t1", 32'(busy), 32'd1);
        check("t3_sb_drained", 32'(sb.size()), 32'd0);
        tick();
        check("t3_busy_t2", 32'(busy), 32'd0);
        check("t3_writes", 32'(n_wr), 32'd0);

        // 4) request held high; bench mirrors count_we into count_in
        set_word(0, 5); set_word(1, 6); set_word(2, 8);
        count_in = 3;
        push_exp(1'b0, 32'd5, 32'd2, -1);
        push_exp(1'b0, 32'd6, 32'd1, -1);
        push_exp(1'b0, 32'd8, 32'd0, -1);
        push_exp(1'b1, 32'd0, 32'd0, -1);
        deq_req = 1'b1;
        for (int i = 0; i < 60 && sb.size() > 0; i++) begin
            tick();
            if (count_we) count_in = count_out;
            if (deq_empty) deq_req = 1'b0;
        end
        deq_req = 1'b0;
        check("t4_drain", 32'(sb.size()), 32'd0);
        tick();

        // 5) requests and a count change while busy are ignored
        set_word(0, 1); set_word(1, 2); set_word(2, 3);
        n_val = 0;
        count_in = 3;
        push_exp(1'b0, 32'd1, 32'd2, 7);
        deq_req = 1'b1;
        tick();
        deq_req = 1'b0;
        tick();
        deq_req  = 1'b1;
        count_in = 9;
        tick();
        deq_req = 1'b0;
        drain(20);
        repeat (10) tick();
        check("t5_valid_count", 32'(n_val), 32'd1);

        // Clamp: count 40 behaves as 16
        for (int i = 0; i < 16; i++) set_word(i, 32'(2 * i + 1));
        n_wr = 0;
        count_in = 40;
        push_exp(1'b0, 32'd1, 32'd15, 33);
        deq_req = 1'b1;
        tick();
        deq_req = 1'b0;
        drain(50);
        check("clamp_writes", 32'(n_wr), 32'd15);
        check("clamp_mem14", mem[14], 32'd31);
        tick();

        // 6) reset during the first S_SH_WR aborts immediately
        set_word(0, 10); set_word(1, 20); set_word(2, 30); set_word(3, 40);
        count_in = 4;
        deq_req = 1'b1;
        tick();
        deq_req = 1'b0;
        repeat (3) tick();
        check("t6_in_shwr", 32'(bram_we), 32'd1);
        rst = 1'b1;
        tick();
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_bram_we", 32'(bram_we), 32'd0);
        check("t6_deq_valid", 32'(deq_valid), 32'd0);
        rst  = 1'b0;
        n_wr = 0;
        repeat (12) tick();
        check("t6_no_writes", 32'(n_wr), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);
        check("t6_mem0", mem[0], 32'd20);
        check("t6_mem1", mem[1], 32'd20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
